core_memory_scheduler: RTL and testbench
========================================

# core_memory_scheduler

Multi-core external-memory scheduler between the per-core global-memory request ports and the DDR3 MIG application (app_*) interface. It arbitrates round-robin among NUM_CORES requesters and serialises one 32-bit word transaction at a time. Each word access becomes a full-line MIG command: reads extract the addressed word, and writes use byte masking. It replaces the fixed one-hot core mux and supplies the missing request-driven read/write state machine.

## Interface
- NUM_CORES, 16, number of requesting cores (2..32)
- ADDR_WIDTH, 28, MIG app_addr width
- APP_DATA_WIDTH, 128, MIG line width in bits (64/128/256); WORDS = APP_DATA_WIDTH/32
- DQ_WIDTH, 16, DDR data width; app_addr unit = DQ_WIDTH/8 bytes
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- core_req  in  NUM_CORES  per-core request; held until matching core_ack
- core_we  in  NUM_CORES  1 = write, 0 = read
- core_addr  in  NUM_CORES*32  per-core byte address, word-aligned; core i at [32i+31:32i]
- core_wdata  in  NUM_CORES*32  per-core write word
- core_grant  out  NUM_CORES  one-hot owner of the in-flight transaction
- core_ack  out  NUM_CORES  one-cycle completion pulse
- core_rdata  out  32  read word, valid with core_ack of a read
- busy  out  1  transaction in flight (state != IDLE)
- init_calib_complete  in  1  MIG calibration done
- app_rdy, app_wdf_rdy  in  1 each  MIG command / write-data ready
- app_rd_data  in  APP_DATA_WIDTH  read line
- app_rd_data_valid  in  1  read line valid
- app_addr  out  ADDR_WIDTH; app_cmd  out  3 (000 write, 001 read); app_en  out  1
- app_wdf_data  out  APP_DATA_WIDTH; app_wdf_mask  out  APP_DATA_WIDTH/8 (1 = byte not written)
- app_wdf_wren, app_wdf_end  out  1 each (app_wdf_end == app_wdf_wren)

## Operation
- States: IDLE, WRITE, READ, READ_WAIT, DONE.
- IDLE:
  - Enter only when init_calib_complete = 1 and core_req is not 0.
  - Winner = first requesting index after rr_ptr, modulo NUM_CORES.
  - Latch the winner's we/addr/wdata; set core_grant one-hot; set rr_ptr = winner.
  - Go to WRITE or READ.
- Address mapping:
  - app_addr = (addr / (DQ_WIDTH/8)), low log2(APP_DATA_WIDTH/DQ_WIDTH) bits forced to 0, truncated to ADDR_WIDTH.
  - sel = addr[log2(APP_DATA_WIDTH/8)-1:2].
- WRITE:
  - app_wdf_data = wdata replicated WORDS times.
  - app_wdf_mask = all ones except 4 zero bits at [4*sel+3:4*sel].
  - app_en and app_wdf_wren assert together.
  - Each drops independently after its handshake (app_en&app_rdy, app_wdf_wren&app_wdf_rdy); completion flags are tracked separately.
  - When both are done, go to DONE.
- READ: app_en with cmd 001 until app_rdy, then go to READ_WAIT.
- READ_WAIT: on app_rd_data_valid, core_rdata <= app_rd_data[32*sel+31:32*sel], then go to DONE.
- DONE: pulse core_ack[owner] for 1 cycle, clear core_grant, return to IDLE.
- app_rd_data_valid outside READ_WAIT is ignored.
- Reset values:
  - All outputs 0, except app_wdf_mask all ones.
  - rr_ptr = NUM_CORES-1, so core 0 wins first.
- Reset mid-transaction: return to IDLE and abandon the in-flight MIG command; its late read data is dropped.
- Calibration falling while busy: the current transaction completes; no new grant is issued.

## Timing
- Request sampled in IDLE → grant and app_en/app_wdf_wren registered the next cycle.
- Write with ready=1: req@T0, app_en@T1, DONE@T2, core_ack@T2. Minimum req-to-ack latency is 2 cycles.
- Read: ack 1 cycle after app_rd_data_valid. core_rdata holds until the next read completes.
- A core holding core_req after ack re-enters arbitration in IDLE; ack-to-next-grant is at least 1 cycle.
- All app_* outputs are registered. app_en holds its value while app_rdy = 0 (MIG stability rule).

## Test plan
- Reset, calib = 1, core 3 writes 0xDEADBEEF at 0x0000_0014, ready = 1:
  - app_addr = 0x8, app_cmd = 0, sel = 1.
  - app_wdf_mask = 0xFF0F, data replicated.
  - core_ack[3] is 2 cycles after req.
- Core 5 reads 0x0000_0008, MIG returns 0x44444444_33333333_22222222_11111111 after 10 cycles:
  - core_rdata = 0x33333333.
  - ack[5] 1 cycle after valid.
- Cores 0, 2, 7 request continuously: grant order 0, 2, 7, 0, 2, 7…; no starvation.
- app_rdy held 0 for 5 cycles while app_wdf_rdy = 1:
  - wdf handshake completes first, app_en stays high.
  - Exactly one write command is issued; a single ack.
- init_calib_complete = 0 with requests pending: no grant and no app_en until calib rises.
- Reset asserted in READ_WAIT, then a stray app_rd_data_valid arrives: no ack; all outputs at reset values.

Source files
------------

// File: rtl/core_memory_scheduler_if.sv
// Bundles the per-core request ports and the MIG app_* interface.
// master = scheduler view, slave = cores + MIG view.
interface core_memory_scheduler_if #(
  parameter int NUM_CORES      = 16,
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128
);
  logic [NUM_CORES-1:0]      core_req;
  logic [NUM_CORES-1:0]      core_we;
  logic [NUM_CORES*32-1:0]   core_addr;
  logic [NUM_CORES*32-1:0]   core_wdata;
  logic [NUM_CORES-1:0]      core_grant;
  logic [NUM_CORES-1:0]      core_ack;
  logic [31:0]               core_rdata;
  logic                      busy;
  logic                      init_calib_complete;
  logic                      app_rdy;
  logic                      app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;

  modport master (
    input  core_req, core_we, core_addr, core_wdata, init_calib_complete,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output core_grant, core_ack, core_rdata, busy,
           app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport slave (
    output core_req, core_we, core_addr, core_wdata, init_calib_complete,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  core_grant, core_ack, core_rdata, busy,
           app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/core_memory_scheduler.sv
// Round-robin scheduler turning single-word core requests into full-line MIG commands.
// One transaction in flight; write ack 2 cycles after request, read ack 1 cycle after read data.
module core_memory_scheduler #(
  parameter int NUM_CORES      = 16,
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int DQ_WIDTH       = 16
) (
  input logic clk,
  input logic reset,
  core_memory_scheduler_if.master bus
);
  localparam int PW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int WORDS = APP_DATA_WIDTH / 32;
  localparam int MW    = APP_DATA_WIDTH / 8;
  localparam int SELW  = $clog2(APP_DATA_WIDTH / 8) - 2;
  localparam int DS    = $clog2(DQ_WIDTH / 8);
  localparam int LB    = $clog2(APP_DATA_WIDTH / DQ_WIDTH);
  localparam logic [31:0] LMASK = (32'd1 << LB) - 32'd1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_READ_WAIT, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [PW-1:0]             rr_ptr;
  logic [SELW-1:0]           sel_q;
  logic                      cmd_done, wdf_done;
  logic [NUM_CORES-1:0]      grant;
  logic [NUM_CORES-1:0]      ack;
  logic [31:0]               rdata;
  logic                      busy_w;
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en, app_wdf_wren;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [MW-1:0]             app_wdf_mask;

  logic                      win_found;
  logic [PW-1:0]             win_idx;
  int                        idx;
  logic [31:0]               win_addr, win_wdata;
  logic                      win_we, start;
  logic [SELW-1:0]           win_sel;
  logic                      cmd_hs, wdf_hs;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!win_found && bus.core_req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  assign win_addr  = bus.core_addr[{win_idx, 5'b0} +: 32];
  assign win_wdata = bus.core_wdata[{win_idx, 5'b0} +: 32];
  assign win_we    = bus.core_we[win_idx];
  assign win_sel   = win_addr[SELW+1:2];
  assign start     = bus.init_calib_complete && win_found;
  assign cmd_hs    = app_en && bus.app_rdy;
  assign wdf_hs    = app_wdf_wren && bus.app_wdf_rdy;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = win_we ? S_WRITE : S_READ;
      S_WRITE:     if ((cmd_done || cmd_hs) && (wdf_done || wdf_hs)) state_nxt = S_DONE;
      S_READ:      if (cmd_hs) state_nxt = S_READ_WAIT;
      S_READ_WAIT: if (bus.app_rd_data_valid) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack    = (state == S_DONE) ? grant : '0;
    busy_w = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr       <= PW'(NUM_CORES - 1);
      sel_q        <= '0;
      cmd_done     <= 1'b0;
      wdf_done     <= 1'b0;
      grant        <= '0;
      rdata        <= '0;
      app_addr     <= '0;
      app_cmd      <= 3'b000;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '1;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_done <= 1'b0;
          wdf_done <= 1'b0;
          if (start) begin
            grant    <= NUM_CORES'(1) << win_idx;
            rr_ptr   <= win_idx;
            sel_q    <= win_sel;
            app_addr <= ADDR_WIDTH'((win_addr >> DS) & ~LMASK);
            app_cmd  <= win_we ? 3'b000 : 3'b001;
            app_en   <= 1'b1;
            if (win_we) begin
              app_wdf_wren <= 1'b1;
              app_wdf_data <= {WORDS{win_wdata}};
              app_wdf_mask <= ~(MW'(4'hF) << {win_sel, 2'b00});
            end
          end
        end
        // Command and data channels complete independently of each other.
        S_WRITE: begin
          if (cmd_hs) begin
            app_en   <= 1'b0;
            cmd_done <= 1'b1;
          end
          if (wdf_hs) begin
            app_wdf_wren <= 1'b0;
            wdf_done     <= 1'b1;
          end
        end
        S_READ: if (cmd_hs) app_en <= 1'b0;
        S_READ_WAIT: if (bus.app_rd_data_valid) rdata <= bus.app_rd_data[{sel_q, 5'b0} +: 32];
        S_DONE: begin
          grant        <= '0;
          app_wdf_mask <= '1;
        end
        default: ;
      endcase
    end
  end

  assign bus.core_grant   = grant;
  assign bus.core_ack     = ack;
  assign bus.core_rdata   = rdata;
  assign bus.busy         = busy_w;
  assign bus.app_addr     = app_addr;
  assign bus.app_cmd      = app_cmd;
  assign bus.app_en       = app_en;
  assign bus.app_wdf_data = app_wdf_data;
  assign bus.app_wdf_mask = app_wdf_mask;
  assign bus.app_wdf_wren = app_wdf_wren;
  assign bus.app_wdf_end  = app_wdf_wren;
endmodule

// File: tb/tb_core_memory_scheduler.sv
// Directed bench for core_memory_scheduler: inputs change 1ns after posedge, outputs sampled there too.
module tb_core_memory_scheduler;
  localparam int NC = 16;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int DQ = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  core_memory_scheduler_if #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW)) bus ();

  core_memory_scheduler #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .DQ_WIDTH(DQ)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.core_req[c] = req;
    bus.core_we[c]  = we;
    bus.core_addr[32*c +: 32]  = addr;
    bus.core_wdata[32*c +: 32] = wdata;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++; if (bus.core_grant !== '0) begin errors++; $display("FAIL reset_grant got=%h exp=0", bus.core_grant); end
    checks++; if (bus.core_ack !== '0) begin errors++; $display("FAIL reset_ack got=%h exp=0", bus.core_ack); end
    checks++; if (bus.core_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.core_rdata); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.app_en !== 1'b0) begin errors++; $display("FAIL reset_app_en got=%b exp=0", bus.app_en); end
    checks++; if (bus.app_wdf_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b exp=0", bus.app_wdf_wren); end
    checks++; if (bus.app_wdf_mask !== 16'hFFFF) begin errors++; $display("FAIL reset_mask got=%h exp=ffff", bus.app_wdf_mask); end
    checks++; if (bus.app_addr !== 28'h0) begin errors++; $display("FAIL reset_app_addr got=%h exp=0", bus.app_addr); end
    reset = 1'b1;
  endtask

  task automatic test_write();
    logic [DW-1:0] exp_data;
    exp_data = {4{32'hDEADBEEF}};
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    set_core(3, 1'b1, 1'b1, 32'h0000_0014, 32'hDEADBEEF);
    step();
    checks++; if (bus.core_grant !== 16'h0008) begin errors++; $display("FAIL wr_grant got=%h exp=0008", bus.core_grant); end
    checks++; if (bus.app_en !== 1'b1 || bus.app_wdf_wren !== 1'b1) begin errors++; $display("FAIL wr_en got=%b%b exp=11", bus.app_en, bus.app_wdf_wren); end
    checks++; if (bus.app_wdf_end !== 1'b1) begin errors++; $display("FAIL wr_end got=%b exp=1", bus.app_wdf_end); end
    checks++; if (bus.app_addr !== 28'h8) begin errors++; $display("FAIL wr_addr got=%h exp=8", bus.app_addr); end
    checks++; if (bus.app_cmd !== 3'b000) begin errors++; $display("FAIL wr_cmd got=%b exp=000", bus.app_cmd); end
    checks++; if (bus.app_wdf_mask !== 16'hFF0F) begin errors++; $display("FAIL wr_mask got=%h exp=ff0f", bus.app_wdf_mask); end
    checks++; if (bus.app_wdf_data !== exp_data) begin errors++; $display("FAIL wr_data got=%h exp=%h", bus.app_wdf_data, exp_data); end
    checks++; if (bus.core_ack !== '0) begin errors++; $display("FAIL wr_early_ack got=%h exp=0", bus.core_ack); end
    step();
    checks++; if (bus.core_ack !== 16'h0008) begin errors++; $display("FAIL wr_ack got=%h exp=0008", bus.core_ack); end
    checks++; if (bus.app_en !== 1'b0 || bus.app_wdf_wren !== 1'b0) begin errors++; $display("FAIL wr_drop got=%b%b exp=00", bus.app_en, bus.app_wdf_wren); end
    set_core(3, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checks++; if (bus.core_ack !== '0 || bus.busy !== 1'b0 || bus.core_grant !== '0) begin errors++; $display("FAIL wr_idle got=ack %h busy %b grant %h exp=0", bus.core_ack, bus.busy, bus.core_grant); end
  endtask

  task automatic test_read();
    logic early_ack;
    early_ack = 1'b0;
    set_core(5, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    step();
    checks++; if (bus.core_grant !== 16'h0020) begin errors++; $display("FAIL rd_grant got=%h exp=0020", bus.core_grant); end
    checks++; if (bus.app_en !== 1'b1 || bus.app_cmd !== 3'b001) begin errors++; $display("FAIL rd_cmd got=en %b cmd %b exp=1 001", bus.app_en, bus.app_cmd); end
    checks++; if (bus.app_addr !== 28'h0) begin errors++; $display("FAIL rd_addr got=%h exp=0", bus.app_addr); end
    checks++; if (bus.app_wdf_wren !== 1'b0) begin errors++; $display("FAIL rd_wren got=%b exp=0", bus.app_wdf_wren); end
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.core_ack !== '0 || bus.app_en !== 1'b0) early_ack = 1'b1;
    end
    checks++; if (early_ack !== 1'b0) begin errors++; $display("FAIL rd_wait got=ack or app_en during wait exp=none"); end
    bus.app_rd_data = 128'h44444444_33333333_22222222_11111111;
    bus.app_rd_data_valid = 1'b1;
    step();
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data = '0;
    checks++; if (bus.core_ack !== 16'h0020) begin errors++; $display("FAIL rd_ack got=%h exp=0020", bus.core_ack); end
    checks++; if (bus.core_rdata !== 32'h33333333) begin errors++; $display("FAIL rd_data got=%h exp=33333333", bus.core_rdata); end
    set_core(5, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checks++; if (bus.core_ack !== '0 || bus.core_rdata !== 32'h33333333) begin errors++; $display("FAIL rd_hold got=ack %h data %h exp=0 33333333", bus.core_ack, bus.core_rdata); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_o[6];
    logic [NC-1:0] prev;
    exp_o = '{0, 2, 7, 0, 2, 7};
    prev = '0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    set_core(0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_00A0);
    set_core(2, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_00A2);
    set_core(7, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_00A7);
    for (int cyc = 0; cyc < 60 && order.size() < 6; cyc++) begin
      step();
      if (bus.core_grant !== '0 && prev === '0) begin
        for (int i = 0; i < NC; i++) if (bus.core_grant[i] === 1'b1) order.push_back(i);
      end
      prev = bus.core_grant;
    end
    set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_core(2, 1'b0, 1'b0, 32'h0, 32'h0);
    set_core(7, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= order.size()) begin errors++; $display("FAIL rr_order[%0d] got=timeout exp=%0d", i, exp_o[i]); end
      else if (order[i] != exp_o[i]) begin errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], exp_o[i]); end
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_cmd_stall();
    int cmd_hs, wdf_hs, acks;
    logic stall_ok, wdf_first;
    cmd_hs = 0; wdf_hs = 0; acks = 0;
    stall_ok = 1'b1; wdf_first = 1'b0;
    bus.app_rdy = 1'b0;
    bus.app_wdf_rdy = 1'b1;
    set_core(1, 1'b1, 1'b1, 32'h0000_0000, 32'h12345678);
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      if (bus.core_ack[1] === 1'b1) begin
        acks++;
        bus.core_req[1] = 1'b0;
      end
      if (cyc <= 5 && bus.app_en !== 1'b1) stall_ok = 1'b0;
      if (cyc == 1 && bus.app_wdf_wren === 1'b0 && bus.app_en === 1'b1) wdf_first = 1'b1;
      bus.app_rdy = (cyc >= 5);
      if (bus.app_en === 1'b1 && bus.app_rdy === 1'b1) cmd_hs++;
      if (bus.app_wdf_wren === 1'b1 && bus.app_wdf_rdy === 1'b1) wdf_hs++;
    end
    bus.app_rdy = 1'b1;
    checks++; if (stall_ok !== 1'b1) begin errors++; $display("FAIL stall_en_held got=dropped exp=held"); end
    checks++; if (wdf_first !== 1'b1) begin errors++; $display("FAIL stall_wdf_first got=%b exp=1", wdf_first); end
    checks++; if (cmd_hs != 1) begin errors++; $display("FAIL stall_cmd_count got=%0d exp=1", cmd_hs); end
    checks++; if (wdf_hs != 1) begin errors++; $display("FAIL stall_wdf_count got=%0d exp=1", wdf_hs); end
    checks++; if (acks != 1) begin errors++; $display("FAIL stall_acks got=%0d exp=1", acks); end
  endtask

  task automatic test_calib();
    logic quiet;
    logic got_ack;
    quiet = 1'b1;
    got_ack = 1'b0;
    bus.init_calib_complete = 1'b0;
    set_core(4, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0044);
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.core_grant !== '0 || bus.app_en !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL calib_quiet got=activity exp=none"); end
    bus.init_calib_complete = 1'b1;
    step();
    checks++; if (bus.core_grant !== 16'h0010 || bus.app_en !== 1'b1) begin errors++; $display("FAIL calib_grant got=grant %h en %b exp=0010 1", bus.core_grant, bus.app_en); end
    for (int i = 0; i < 10 && !got_ack; i++) begin
      step();
      if (bus.core_ack[4] === 1'b1) begin
        got_ack = 1'b1;
        bus.core_req[4] = 1'b0;
      end
    end
    checks++; if (got_ack !== 1'b1) begin errors++; $display("FAIL calib_ack got=timeout exp=ack"); end
    step();
  endtask

  task automatic test_reset_in_read_wait();
    logic stray;
    stray = 1'b0;
    set_core(2, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    step();
    step();
    checks++; if (bus.busy !== 1'b1 || bus.app_en !== 1'b0) begin errors++; $display("FAIL rst_rw_setup got=busy %b en %b exp=1 0", bus.busy, bus.app_en); end
    reset = 1'b0;
    set_core(2, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    reset = 1'b1;
    bus.app_rd_data = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    bus.app_rd_data_valid = 1'b1;
    step();
    bus.app_rd_data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.core_ack !== '0) stray = 1'b1;
      step();
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rst_rw_ack got=ack exp=none"); end
    checks++; if (bus.busy !== 1'b0 || bus.core_grant !== '0) begin errors++; $display("FAIL rst_rw_idle got=busy %b grant %h exp=0 0", bus.busy, bus.core_grant); end
    checks++; if (bus.core_rdata !== 32'h0) begin errors++; $display("FAIL rst_rw_rdata got=%h exp=0", bus.core_rdata); end
    checks++; if (bus.app_en !== 1'b0 || bus.app_wdf_mask !== 16'hFFFF) begin errors++; $display("FAIL rst_rw_app got=en %b mask %h exp=0 ffff", bus.app_en, bus.app_wdf_mask); end
  endtask

  initial begin
    bus.core_req = '0;
    bus.core_we = '0;
    bus.core_addr = '0;
    bus.core_wdata = '0;
    bus.init_calib_complete = 1'b1;
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    bus.app_rd_data = '0;
    bus.app_rd_data_valid = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_cmd_stall();
    test_calib();
    test_reset_in_read_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
